// File: rtl/la_capture_pkg.sv
// Shared types and helpers for the logic-analyzer trigger/capture engine.
package la_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_READOUT = 3'd4,
    ST_DONE    = 3'd5
  } cap_state_e;

  // Pre-trigger history can never use the whole ring: at least one slot
  // must stay free for the trigger sample.
  function automatic int unsigned clamp_pre(input int unsigned len, input int unsigned depth);
    return (len > depth - 1) ? depth - 1 : len;
  endfunction

  // Post-trigger length fills at most the room the pre window left, and the
  // trigger sample itself is always captured.
  function automatic int unsigned clamp_post(input int unsigned len, input int unsigned pre,
                                             input int unsigned depth);
    int unsigned r;
    r = (len > depth - pre) ? depth - pre : len;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/la_capture_ram.sv
// Simple dual-port capture buffer: synchronous write, one-cycle registered read.
module la_capture_ram
  import la_capture_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage array without reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/la_trigger_capture.sv
// Pre/post-trigger capture engine: ring-buffered history, mask/value/edge
// trigger, and a bubble-free valid/ready readout of the captured window.
module la_trigger_capture
  import la_capture_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int DEPTH        = 1024,
  parameter int ADDR_BITS    = $clog2(DEPTH)
) (
  input  logic                    clk_250mhz,
  input  logic                    rst_n,
  input  logic                    samples_valid,
  input  logic [NUM_CHANNELS-1:0] samples,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    force_trig,
  input  logic [NUM_CHANNELS-1:0] trig_mask,
  input  logic [NUM_CHANNELS-1:0] trig_value,
  input  logic [NUM_CHANNELS-1:0] trig_edge_mask,
  input  logic [ADDR_BITS:0]      pretrig_len,
  input  logic [ADDR_BITS:0]      posttrig_len,
  output logic [2:0]              state_out,
  output logic                    triggered,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CHANNELS-1:0] out_data,
  output logic                    out_last
);

  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  cap_state_e state_q, state_d;
  logic [CW-1:0] pre_q, pre_d, post_q, post_d, len_q, len_d, cnt_q, cnt_d;
  logic [CW-1:0] issued_q, issued_d, pre_c, post_c;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d, value_q, value_d, edge_q, edge_d, prev_q, prev_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, trig_addr_q, trig_addr_d, rd_addr_q, rd_addr_d;
  logic triggered_q, triggered_d, inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic wr_en, rd_en, trig_hit, pop, rd_space, skid_tail;
  logic [NUM_CHANNELS-1:0] rd_data;
  logic [NUM_CHANNELS-1:0] skid_data_q [2];
  logic [1:0] skid_last_q, skid_cnt_q;
  logic skid_head_q;

  assign pre_c  = CW'(clamp_pre(32'(pretrig_len), $unsigned(DEPTH)));
  assign post_c = CW'(clamp_post(32'(posttrig_len), 32'(pre_c), $unsigned(DEPTH)));

  assign trig_hit = samples_valid && (((samples ^ value_q) & mask_q) == '0) &&
                    ((edge_q == '0) || (|(edge_q & samples & ~prev_q)));

  assign out_valid = (skid_cnt_q != 2'd0) && !abort;
  assign pop       = out_valid && out_ready;
  assign out_data  = skid_data_q[skid_head_q];
  assign out_last  = out_valid && skid_last_q[skid_head_q];
  assign skid_tail = skid_head_q ^ skid_cnt_q[0];
  assign rd_space  = (({1'b0, skid_cnt_q} + {2'b00, inflight_q}) < 3'd2) || pop;

  assign state_out = state_q;
  assign triggered = triggered_q;
  assign done      = (state_q == ST_DONE);

  la_capture_ram #(
    .WIDTH(NUM_CHANNELS), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk_i(clk_250mhz), .wr_en_i(wr_en), .wr_addr_i(wr_ptr_q), .wr_data_i(samples),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr_q), .rd_data_o(rd_data)
  );

  // Next-state logic: capture sequencing, trigger handling and readout issue.
  always_comb begin
    state_d = state_q;  pre_d = pre_q;  post_d = post_q;  len_d = len_q;  cnt_d = cnt_q;
    mask_d = mask_q;  value_d = value_q;  edge_d = edge_q;  prev_d = prev_q;
    wr_ptr_d = wr_ptr_q;  trig_addr_d = trig_addr_q;  rd_addr_d = rd_addr_q;
    issued_d = issued_q;  triggered_d = triggered_q;
    wr_en = 1'b0;  rd_en = 1'b0;

    if ((state_q inside {ST_FILL, ST_ARMED, ST_POST}) && samples_valid) prev_d = samples;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          pre_d = pre_c;  post_d = post_c;  len_d = pre_c + post_c;
          mask_d = trig_mask;  value_d = trig_value;  edge_d = trig_edge_mask;
          triggered_d = 1'b0;  wr_ptr_d = '0;  cnt_d = '0;  prev_d = '0;
          state_d = (pre_c == '0) ? ST_ARMED : ST_FILL;
        end
      end
      ST_FILL: begin
        if (samples_valid) begin
          wr_en = 1'b1;  wr_ptr_d = wr_ptr_q + 1'b1;  cnt_d = cnt_q + ONE;
          if (cnt_q + ONE == pre_q) begin
            state_d = ST_ARMED;  cnt_d = '0;
          end
        end
      end
      ST_ARMED: begin
        if (samples_valid) begin
          wr_en = 1'b1;  wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (trig_hit || force_trig) begin
          triggered_d = 1'b1;  trig_addr_d = wr_ptr_q;
          cnt_d = samples_valid ? ONE : '0;
          state_d = (samples_valid && post_q == ONE) ? ST_READOUT : ST_POST;
        end
      end
      ST_POST: begin
        if (samples_valid) begin
          wr_en = 1'b1;  wr_ptr_d = wr_ptr_q + 1'b1;  cnt_d = cnt_q + ONE;
          if (cnt_q + ONE == post_q) state_d = ST_READOUT;
        end
      end
      ST_READOUT: begin
        if ((issued_q < len_q) && rd_space) begin
          rd_en = 1'b1;  rd_addr_d = rd_addr_q + 1'b1;  issued_d = issued_q + ONE;
        end
        if (pop && out_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d      = rd_en;
    inflight_last_d = rd_en && (issued_q == len_q - ONE);

    if (state_q != ST_READOUT && state_d == ST_READOUT) begin
      rd_addr_d = trig_addr_d - pre_q[ADDR_BITS-1:0];
      issued_d  = '0;
    end

    if (abort) begin
      state_d = ST_IDLE;  triggered_d = 1'b0;  issued_d = '0;
      inflight_d = 1'b0;  inflight_last_d = 1'b0;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk_250mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  pre_q <= '0;  post_q <= '0;  len_q <= '0;  cnt_q <= '0;
      mask_q <= '0;  value_q <= '0;  edge_q <= '0;  prev_q <= '0;
      wr_ptr_q <= '0;  trig_addr_q <= '0;  rd_addr_q <= '0;  issued_q <= '0;
      triggered_q <= 1'b0;  inflight_q <= 1'b0;  inflight_last_q <= 1'b0;
    end else begin
      state_q <= state_d;  pre_q <= pre_d;  post_q <= post_d;  len_q <= len_d;  cnt_q <= cnt_d;
      mask_q <= mask_d;  value_q <= value_d;  edge_q <= edge_d;  prev_q <= prev_d;
      wr_ptr_q <= wr_ptr_d;  trig_addr_q <= trig_addr_d;  rd_addr_q <= rd_addr_d;
      issued_q <= issued_d;  triggered_q <= triggered_d;
      inflight_q <= inflight_d;  inflight_last_q <= inflight_last_d;
    end
  end

  // Two-entry output skid that absorbs the RAM read latency under backpressure.
  always_ff @(posedge clk_250mhz or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_q[0] <= '0;  skid_data_q[1] <= '0;
      skid_last_q <= '0;  skid_cnt_q <= '0;  skid_head_q <= 1'b0;
    end else if (abort) begin
      skid_cnt_q <= '0;  skid_head_q <= 1'b0;
    end else begin
      if (inflight_q) begin
        skid_data_q[skid_tail] <= rd_data;
        skid_last_q[skid_tail] <= inflight_last_q;
      end
      if (pop) skid_head_q <= ~skid_head_q;
      skid_cnt_q <= skid_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_la_trigger_capture.sv
// Scoreboard bench for la_trigger_capture with a 16-deep ring and 16 channels.
module tb_la_trigger_capture;
  import la_capture_pkg::*;

  logic        clk_250mhz = 1'b0;
  logic        rst_n, samples_valid, arm, abort, force_trig, out_ready;
  logic [15:0] samples, trig_mask, trig_value, trig_edge_mask;
  logic [4:0]  pretrig_len, posttrig_len;
  logic [2:0]  state_out;
  logic        triggered, done, out_valid, out_last;
  logic [15:0] out_data;

  int          errors = 0;
  int          checks = 0;
  int          beats  = 0;
  logic [16:0] expQ[$];
  logic [15:0] rampVal = 16'd0;
  logic        stalled = 1'b0;
  logic [16:0] held = '0;

  la_trigger_capture #(.NUM_CHANNELS(16), .DEPTH(16)) dut (
    .clk_250mhz(clk_250mhz), .rst_n(rst_n), .samples_valid(samples_valid), .samples(samples),
    .arm(arm), .abort(abort), .force_trig(force_trig), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_edge_mask(trig_edge_mask), .pretrig_len(pretrig_len),
    .posttrig_len(posttrig_len), .state_out(state_out), .triggered(triggered), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #2 clk_250mhz = ~clk_250mhz;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic a,
                               input logic ab, input logic f);
    samples_valid = v;  samples = d;  arm = a;  abort = ab;  force_trig = f;
    @(posedge clk_250mhz);
    #1;
    samples_valid = 1'b0;  arm = 1'b0;  abort = 1'b0;  force_trig = 1'b0;
  endtask

  task automatic stepRamp(input logic en, input logic a, input logic ab, input logic f);
    applyStimulus(en, rampVal, a, ab, f);
    if (en) rampVal = rampVal + 16'd1;
  endtask

  task automatic setConfig(input logic [15:0] m, input logic [15:0] v, input logic [15:0] e,
                           input logic [4:0] pre, input logic [4:0] post);
    trig_mask = m;  trig_value = v;  trig_edge_mask = e;  pretrig_len = pre;  posttrig_len = post;
  endtask

  task automatic pushRange(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) expQ.push_back({(i == n - 1), 16'(start + 16'(i))});
  endtask

  task automatic runWindow(input int readyPct, input string tag);
    int c = 0;
    while (done !== 1'b1 && c < 400) begin
      out_ready = ($urandom_range(0, 99) < readyPct);
      stepRamp(1'b1, 1'b0, 1'b0, 1'b0);
      c++;
    end
    out_ready = 1'b1;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_state"}, 32'(state_out), 32'(ST_DONE));
    checkOutput({tag, "_triggered"}, 32'(triggered), 32'd1);
    checkOutput({tag, "_drained"}, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic [16:0] exp;
    forever begin
      @(negedge clk_250mhz);
      if (stalled && !abort) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_beat", 32'({out_last, out_data}), 32'(held));
      end
      stalled = out_valid && !out_ready;
      held    = {out_last, out_data};
      if (out_valid && out_ready) begin
        beats++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_beat: got data 0x%0h last %0d, expected no beat", out_data, out_last);
        end else begin
          exp = expQ.pop_front();
          checkOutput("beat_data", 32'(out_data), 32'(exp[15:0]));
          checkOutput("beat_last", 32'(out_last), 32'(exp[16]));
        end
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0;  samples_valid = 1'b0;  samples = '0;  arm = 1'b0;  abort = 1'b0;
    force_trig = 1'b0;  out_ready = 1'b1;
    setConfig(16'h0, 16'h0, 16'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk_250mhz);
    #1;
    checkOutput("rst_state", 32'(state_out), 32'(ST_IDLE));
    checkOutput("rst_triggered", 32'(triggered), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_250mhz);
    #1;

    $display("[TB] test 1: value trigger, pre=4 post=4");
    setConfig(16'hFFFF, 16'h0020, 16'h0, 5'd4, 5'd4);
    rampVal = 16'h0000;
    pushRange(16'h001C, 8);
    stepRamp(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_fill", 32'(state_out), 32'(ST_FILL));
    runWindow(100, "t1");

    $display("[TB] test 2: pre=15 post=10 clamps post to 1");
    setConfig(16'hFFFF, 16'h0120, 16'h0, 5'd15, 5'd10);
    rampVal = 16'h0100;
    pushRange(16'h0111, 16);
    stepRamp(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_fill", 32'(state_out), 32'(ST_FILL));
    checkOutput("t2_trig_cleared", 32'(triggered), 32'd0);
    runWindow(100, "t2");

    $display("[TB] test 3: rising-edge trigger on ch0");
    setConfig(16'h0000, 16'h0000, 16'h0001, 5'd4, 5'd4);
    rampVal = 16'h0200;
    repeat (3) stepRamp(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_pre_arm_done", 32'(state_out), 32'(ST_DONE));
    stepRamp(1'b1, 1'b1, 1'b0, 1'b0);
    pushRange(16'h0205, 8);
    runWindow(100, "t3");

    $display("[TB] test 4: random backpressure");
    setConfig(16'hFFFF, 16'h0020, 16'h0, 5'd4, 5'd4);
    rampVal = 16'h0000;
    pushRange(16'h001C, 8);
    stepRamp(1'b0, 1'b1, 1'b0, 1'b0);
    runWindow(30, "t4");

    $display("[TB] test 5: abort during readout");
    rampVal = 16'h0000;
    pushRange(16'h001C, 8);
    stepRamp(1'b0, 1'b1, 1'b0, 1'b0);
    base = beats;
    for (int c = 0; c < 400 && (beats - base) < 3; c++) stepRamp(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_three_beats", 32'(beats - base), 32'd3);
    stepRamp(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_valid_low", 32'(out_valid), 32'd0);
    checkOutput("t5_idle", 32'(state_out), 32'(ST_IDLE));
    checkOutput("t5_trig_cleared", 32'(triggered), 32'd0);
    checkOutput("t5_remaining", 32'(expQ.size()), 32'd5);
    expQ.delete();
    rampVal = 16'h0000;
    pushRange(16'h001C, 8);
    stepRamp(1'b0, 1'b1, 1'b0, 1'b0);
    runWindow(100, "t5_rearm");

    $display("[TB] test 6: ring wrap then force trigger with no valid sample");
    setConfig(16'hFFFF, 16'hFFFF, 16'h0, 5'd8, 5'd4);
    rampVal = 16'h0300;
    pushRange(16'h0328, 12);
    stepRamp(1'b0, 1'b1, 1'b0, 1'b0);
    setConfig(16'h0000, 16'h0000, 16'h0, 5'd1, 5'd1);
    repeat (48) stepRamp(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_armed", 32'(state_out), 32'(ST_ARMED));
    checkOutput("t6_not_trig", 32'(triggered), 32'd0);
    stepRamp(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_post", 32'(state_out), 32'(ST_POST));
    checkOutput("t6_trig", 32'(triggered), 32'd1);
    runWindow(100, "t6");

    $display("[TB] test 7: pre=0 arms directly");
    setConfig(16'hFFFF, 16'h0405, 16'h0, 5'd0, 5'd3);
    rampVal = 16'h0400;
    pushRange(16'h0405, 3);
    stepRamp(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t7_armed", 32'(state_out), 32'(ST_ARMED));
    runWindow(100, "t7");

    $display("[TB] test 8: arm and abort together");
    stepRamp(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t8_idle", 32'(state_out), 32'(ST_IDLE));
    checkOutput("t8_done_low", 32'(done), 32'd0);

    repeat (2) @(posedge clk_250mhz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
